// File: rtl/lab4d_dma_pkg.sv
// rtl/lab4d_dma_pkg.sv - shared types and constants for the LAB4D DMA engine
// Contents: FSM state enum, default geometry/timeouts, header magic, helpers.
package lab4d_dma_pkg;

    localparam int NUM_LABS      = 12;
    localparam int LAB_ADR_SHIFT = 11;
    localparam int ACK_TIMEOUT   = 255;
    localparam int LOCK_TIMEOUT  = 1023;

    // "LAB4" tag; the L is carried as hex 1 since L is not a hex digit.
    localparam logic [15:0] HDR_MAGIC = 16'h1AB4;

    typedef enum logic [2:0] {
        IDLE,
        LOCK,
        SCAN,
        HDR,
        REQ,
        HOLD,
        UNLOCK
    } dma_state_t;

    // True when any mask bit at or above idx is set.
    function automatic logic any_from(input logic [15:0] mask, input logic [3:0] idx);
        return |(mask >> idx);
    endfunction

endpackage

// File: rtl/lab4d_dma_if.sv
// rtl/lab4d_dma_if.sv - DMA lock, Wishbone read master and output stream bundle
// Ports: dma_lock/locked handshake, wbdma_* Wishbone signals, m_t* stream.
// Modports: master (engine side), slave (RAM + stream sink side).
interface lab4d_dma_if;
    logic        dma_lock_o;
    logic        dma_locked_i;
    logic        wbdma_cyc_o;
    logic        wbdma_stb_o;
    logic        wbdma_we_o;
    logic [15:0] wbdma_adr_o;
    logic [31:0] wbdma_dat_i;
    logic        wbdma_ack_i;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    modport master (
        output dma_lock_o, wbdma_cyc_o, wbdma_stb_o, wbdma_we_o, wbdma_adr_o,
               m_tdata, m_tvalid, m_tlast,
        input  dma_locked_i, wbdma_dat_i, wbdma_ack_i, m_tready
    );

    modport slave (
        input  dma_lock_o, wbdma_cyc_o, wbdma_stb_o, wbdma_we_o, wbdma_adr_o,
               m_tdata, m_tvalid, m_tlast,
        output dma_locked_i, wbdma_dat_i, wbdma_ack_i, m_tready
    );
endinterface

// File: rtl/lab4d_dma_outreg.sv
// rtl/lab4d_dma_outreg.sv - single-entry stream output register with last flag
// Ports: clk, rst (sync, active high); load/load_data/load_last fill the entry;
// mark_last forces tlast on a word still waiting; tdata/tvalid/tlast/tready
// stream side; empty tells the FSM a new word may be loaded.
module lab4d_dma_outreg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        load_last,
    input  logic        mark_last,
    output logic [31:0] tdata,
    output logic        tvalid,
    output logic        tlast,
    input  logic        tready,
    output logic        empty
);

    // load is only asserted by the FSM while the entry is empty, so it never
    // collides with a handshake and the held word stays stable under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            tdata  <= '0;
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end else if (load) begin
            tdata  <= load_data;
            tvalid <= 1'b1;
            tlast  <= load_last;
        end else if (tvalid && tready) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end else if (mark_last && tvalid) begin
            tlast  <= 1'b1;
        end
    end

    assign empty = ~tvalid;

endmodule

// File: rtl/lab4d_dma_engine.sv
// rtl/lab4d_dma_engine.sv - LAB4D sample RAM DMA drain to 32-bit stream
// Ports: clk_i, rst_i (sync, active high); start_i, lab_mask_i, words_i
// control; busy_o, done_o, err_o status; bus (lab4d_dma_if.master) carries
// the DMA lock handshake, Wishbone read master and m_t* output stream.
// Optional: LAB4D_DMA_HEADER_EN emits one header word ahead of each LAB.
module lab4d_dma_engine #(
    parameter int NUM_LABS      = lab4d_dma_pkg::NUM_LABS,
    parameter int LAB_ADR_SHIFT = lab4d_dma_pkg::LAB_ADR_SHIFT,
    parameter int ACK_TIMEOUT   = lab4d_dma_pkg::ACK_TIMEOUT,
    parameter int LOCK_TIMEOUT  = lab4d_dma_pkg::LOCK_TIMEOUT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [NUM_LABS-1:0] lab_mask_i,
    input  logic [9:0]          words_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    lab4d_dma_if.master         bus
);
    import lab4d_dma_pkg::*;

    localparam logic [9:0] ACK_LAST  = 10'(ACK_TIMEOUT - 1);
    localparam logic [9:0] LOCK_LAST = 10'(LOCK_TIMEOUT - 1);

    dma_state_t          state;
    logic [NUM_LABS-1:0] mask_r;
    logic [9:0]          words_r;
    logic [9:0]          word;
    logic [3:0]          lab;
    logic [9:0]          timer;
    logic                busy_r, done_r, err_r, lock_r, cyc_r, stb_r;
    logic [15:0]         adr_r;

    logic                load, load_last, abort, empty, hs;
    logic [31:0]         load_data;
    logic [15:0]         mask16;
    logic                lab_pending, lab_found, more_labs, word_is_last;

    function automatic logic [15:0] word_adr(input logic [3:0] l, input logic [9:0] w);
        return (16'(l) << LAB_ADR_SHIFT) | (16'(w[8:0]) << 2);
    endfunction

    assign mask16       = 16'(mask_r);
    assign lab_pending  = any_from(mask16, lab);
    assign lab_found    = mask16[lab];
    assign more_labs    = any_from(mask16, lab + 4'd1);
    // words_r holds 512 for a zero request, so words_r-1 is 511 as intended.
    assign word_is_last = (word == words_r - 10'd1);
    assign hs           = bus.m_tvalid & bus.m_tready;

    assign abort = ((state == LOCK) && !bus.dma_locked_i && (timer == LOCK_LAST)) ||
                   ((state == REQ)  && !bus.wbdma_ack_i  && (timer == ACK_LAST));

`ifdef LAB4D_DMA_HEADER_EN
    logic [9:0]  hdr_words;
    logic [31:0] hdr_word;
    assign hdr_words = (words_r == 10'd512) ? 10'd0 : words_r;
    assign hdr_word  = {HDR_MAGIC, lab, 2'b00, hdr_words};
`endif

    always_comb begin
        load      = 1'b0;
        load_last = 1'b0;
        load_data = bus.wbdma_dat_i;
        case (state)
            REQ: begin
                if (bus.wbdma_ack_i) begin
                    load      = 1'b1;
                    load_last = word_is_last & ~more_labs;
                end
            end
`ifdef LAB4D_DMA_HEADER_EN
            SCAN: begin
                if (lab_pending && lab_found) begin
                    load      = 1'b1;
                    load_data = hdr_word;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            mask_r  <= '0;
            words_r <= '0;
            word    <= '0;
            lab     <= '0;
            timer   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            lock_r  <= 1'b0;
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            adr_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        mask_r  <= lab_mask_i;
                        words_r <= (words_i == 10'd0) ? 10'd512 : words_i;
                        err_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        lock_r  <= 1'b1;
                        timer   <= '0;
                        lab     <= '0;
                        word    <= '0;
                        state   <= LOCK;
                    end
                end
                LOCK: begin
                    if (bus.dma_locked_i) begin
                        state <= SCAN;
                    end else if (abort) begin
                        err_r  <= 1'b1;
                        lock_r <= 1'b0;
                        state  <= UNLOCK;
                    end else begin
                        timer <= timer + 10'd1;
                    end
                end
                SCAN: begin
                    // Nothing left at or above lab covers both "mask empty"
                    // and "ran past the last LAB".
                    if (!lab_pending) begin
                        lock_r <= 1'b0;
                        state  <= UNLOCK;
                    end else if (lab_found) begin
                        word <= '0;
`ifdef LAB4D_DMA_HEADER_EN
                        state <= HDR;
`else
                        cyc_r <= 1'b1;
                        stb_r <= 1'b1;
                        timer <= '0;
                        adr_r <= word_adr(lab, 10'd0);
                        state <= REQ;
`endif
                    end else begin
                        lab <= lab + 4'd1;
                    end
                end
                HDR: begin
                    if (hs) begin
                        cyc_r <= 1'b1;
                        stb_r <= 1'b1;
                        timer <= '0;
                        adr_r <= word_adr(lab, 10'd0);
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.wbdma_ack_i) begin
                        cyc_r <= 1'b0;
                        stb_r <= 1'b0;
                        state <= HOLD;
                    end else if (abort) begin
                        cyc_r  <= 1'b0;
                        stb_r  <= 1'b0;
                        err_r  <= 1'b1;
                        lock_r <= 1'b0;
                        state  <= UNLOCK;
                    end else begin
                        timer <= timer + 10'd1;
                    end
                end
                HOLD: begin
                    if (hs) begin
                        if (word_is_last) begin
                            lab   <= lab + 4'd1;
                            word  <= '0;
                            state <= SCAN;
                        end else begin
                            word  <= word + 10'd1;
                            cyc_r <= 1'b1;
                            stb_r <= 1'b1;
                            timer <= '0;
                            adr_r <= word_adr(lab, word + 10'd1);
                            state <= REQ;
                        end
                    end
                end
                UNLOCK: begin
                    // A word still held is drained before the transfer ends.
                    if (!bus.dma_locked_i && empty) begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    lab4d_dma_outreg u_outreg (
        .clk       (clk_i),
        .rst       (rst_i),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .mark_last (abort),
        .tdata     (bus.m_tdata),
        .tvalid    (bus.m_tvalid),
        .tlast     (bus.m_tlast),
        .tready    (bus.m_tready),
        .empty     (empty)
    );

    assign busy_o          = busy_r;
    assign done_o          = done_r;
    assign err_o           = err_r;
    assign bus.dma_lock_o  = lock_r;
    assign bus.wbdma_cyc_o = cyc_r;
    assign bus.wbdma_stb_o = stb_r;
    assign bus.wbdma_we_o  = 1'b0;
    assign bus.wbdma_adr_o = adr_r;

endmodule
